muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 157 +++++++++++++++
 tb/tb_muldiv_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, over 32 cycles.
// MTHI/MTLO write HI/LO directly in a single cycle.
module muldiv_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cancel,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;
    localparam logic [5:0] LAST    = 6'(W - 1);

    logic [0:0]   r_state;
    logic [5:0]   r_count;
    logic         r_done;
    logic         r_isDiv;
    logic         r_negLo;
    logic         r_negHi;
    logic         r_divZero;
    logic [W-1:0] r_opB;
    logic [W-1:0] r_upper;
    logic [W-1:0] r_lower;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;

    logic         w_xNeg;
    logic         w_yNeg;
    logic [W-1:0] w_xAbs;
    logic [W-1:0] w_yAbs;
    logic [W-1:0] w_addend;
    logic [W:0]   w_mulSum;
    logic [W:0]   w_shifted;
    logic         w_fits;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_nextUpper;
    logic [W-1:0] w_nextLower;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prodFinal;
    logic [W-1:0] w_quotFinal;
    logic [W-1:0] w_remFinal;

    // Operand magnitudes, one iteration step of either algorithm, and the sign-corrected final results
    always_comb begin
        w_xNeg = op[0] & x[W-1];
        w_yNeg = op[0] & y[W-1];
        w_xAbs = w_xNeg ? -x : x;
        w_yAbs = w_yNeg ? -y : y;

        // multiply: upper accumulates the multiplicand when the current multiplier bit is set,
        // then the whole {upper,lower} pair shifts right by one
        w_addend = r_lower[0] ? r_opB : '0;
        w_mulSum = {1'b0, r_upper} + {1'b0, w_addend};

        // restoring divide: shift the next dividend bit into the partial remainder and try the subtraction;
        // when it fits the difference is below the divisor, so W bits hold it exactly
        w_shifted = {r_upper, r_lower[W-1]};
        w_fits    = (w_shifted >= {1'b0, r_opB});
        w_diff    = w_shifted[W-1:0] - r_opB;

        if (r_isDiv) begin
            w_nextUpper = w_fits ? w_diff : w_shifted[W-1:0];
            w_nextLower = {r_lower[W-2:0], w_fits};
        end else begin
            w_nextUpper = w_mulSum[W:1];
            w_nextLower = {w_mulSum[0], r_lower[W-1:1]};
        end

        w_prod      = {w_nextUpper, w_nextLower};
        w_prodFinal = r_negLo ? -w_prod : w_prod;
        // a zero divisor yields an all-ones quotient regardless of signs; the remainder path already returns x
        w_quotFinal = r_divZero ? '1 : (r_negLo ? -w_nextLower : w_nextLower);
        w_remFinal  = r_negHi ? -w_nextUpper : w_nextUpper;
    end

    // Control FSM, operand latching, iteration registers and the architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_isDiv   <= 1'b0;
            r_negLo   <= 1'b0;
            r_negHi   <= 1'b0;
            r_divZero <= 1'b0;
            r_opB     <= '0;
            r_upper   <= '0;
            r_lower   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            r_state   <= ST_CALC;
                            r_count   <= '0;
                            r_isDiv   <= op[1];
                            r_negLo   <= w_xNeg ^ w_yNeg;
                            r_negHi   <= w_xNeg;
                            r_divZero <= op[1] && (y == '0);
                            r_upper   <= '0;
                            r_opB     <= op[1] ? w_yAbs : w_xAbs;
                            r_lower   <= op[1] ? w_xAbs : w_yAbs;
                        end else if (!op[1]) begin
                            if (op[0]) begin
                                r_lo <= x;
                            end else begin
                                r_hi <= x;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 6'd1;
                        r_upper <= w_nextUpper;
                        r_lower <= w_nextLower;
                        if (r_count == LAST) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            if (r_isDiv) begin
                                r_hi <= w_remFinal;
                                r_lo <= w_quotFinal;
                            end else begin
                                r_hi <= w_prodFinal[2*W-1:W];
                                r_lo <= w_prodFinal[W-1:0];
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_CALC);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scenarios for muldiv_seq with hand-computed results.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nCompared;
    int nMismatched;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    muldiv_seq #(.W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .x      (x),
        .y      (y),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a one-cycle start request; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        x     = a;
        y     = b;
        @(negedge clk);
        start = 1'b0;
        x     = 32'hDEADBEEF;
        y     = 32'h0BADF00D;
    endtask

    // Count negedges with busy high (bounded), then report whether done is high at the first idle negedge
    task automatic wait_idle(output int cycles, output logic gotDone);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        gotDone = done;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'b000;
        x      = '0;
        y      = '0;
        #12;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got=%0h want=0", busy); end
        nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done got=%0h want=0", done); end
        nCompared++; if (hi !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_hi got=%h want=00000000", hi); end
        nCompared++; if (lo !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_lo got=%h want=00000000", lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu();
        int   cyc;
        logic gd;
        // the request is presented right away so it meets the first edge after release
        start = 1'b1; op = OP_MULTU; x = 32'hFFFFFFFF; y = 32'd2;
        @(negedge clk);
        start = 1'b0; x = '0; y = '0;
        nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL multu_first_start busy got=%0h want=1", busy); end
        wait_idle(cyc, gd);
        nCompared++; if (cyc !== 32) begin nMismatched++; $display("[TB] FAIL multu_busy_cycles got=%0d want=32", cyc); end
        nCompared++; if (gd !== 1'b1) begin nMismatched++; $display("[TB] FAIL multu_done got=%0h want=1", gd); end
        nCompared++; if (hi !== 32'h1) begin nMismatched++; $display("[TB] FAIL multu_hi got=%h want=00000001", hi); end
        nCompared++; if (lo !== 32'hFFFFFFFE) begin nMismatched++; $display("[TB] FAIL multu_lo got=%h want=fffffffe", lo); end
        @(negedge clk);
        nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL multu_done_pulse got=%0h want=0", done); end
    endtask

    task automatic test_signed();
        int   cyc;
        logic gd;
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        wait_idle(cyc, gd);
        nCompared++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin nMismatched++; $display("[TB] FAIL mult_neg got=%h_%h want=ffffffff_ffffffeb", hi, lo); end
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc, gd);
        nCompared++; if (lo !== 32'hFFFFFFFD) begin nMismatched++; $display("[TB] FAIL div_quot got=%h want=fffffffd", lo); end
        nCompared++; if (hi !== 32'hFFFFFFFF) begin nMismatched++; $display("[TB] FAIL div_rem got=%h want=ffffffff", hi); end
        issue(OP_DIVU, 32'd1000, 32'd7);
        wait_idle(cyc, gd);
        nCompared++; if ({hi, lo} !== {32'd6, 32'd142}) begin nMismatched++; $display("[TB] FAIL divu_basic got=%h_%h want=00000006_0000008e", hi, lo); end
    endtask

    task automatic test_div_edge();
        int   cyc;
        logic gd;
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_idle(cyc, gd);
        nCompared++; if (cyc !== 32) begin nMismatched++; $display("[TB] FAIL divu_zero_cycles got=%0d want=32", cyc); end
        nCompared++; if ({hi, lo} !== {32'd100, 32'hFFFFFFFF}) begin nMismatched++; $display("[TB] FAIL divu_zero got=%h_%h want=00000064_ffffffff", hi, lo); end
        issue(OP_DIV, 32'hFFFFFFF9, 32'd0);
        wait_idle(cyc, gd);
        nCompared++; if ({hi, lo} !== 64'hFFFFFFF9_FFFFFFFF) begin nMismatched++; $display("[TB] FAIL div_zero_neg got=%h_%h want=fffffff9_ffffffff", hi, lo); end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc, gd);
        nCompared++; if ({hi, lo} !== 64'h00000000_80000000) begin nMismatched++; $display("[TB] FAIL div_overflow got=%h_%h want=00000000_80000000", hi, lo); end
    endtask

    task automatic test_move();
        issue(OP_MTHI, 32'h0000CAFE, 32'd0);
        nCompared++; if (hi !== 32'h0000CAFE) begin nMismatched++; $display("[TB] FAIL mthi_hi got=%h want=0000cafe", hi); end
        nCompared++; if (busy !== 1'b0 || done !== 1'b0) begin nMismatched++; $display("[TB] FAIL mthi_flags got=%0h%0h want=00", busy, done); end
        // reserved opcode touches nothing
        issue(3'b110, 32'h11111111, 32'h2);
        nCompared++; if ({busy, hi, lo} !== {1'b0, 32'h0000CAFE, 32'h80000000}) begin nMismatched++; $display("[TB] FAIL reserved_op got=%0h_%h_%h want=0_0000cafe_80000000", busy, hi, lo); end
    endtask

    task automatic test_start_while_busy();
        int   cyc;
        logic gd;
        issue(OP_MULTU, 32'h12345678, 32'h00000100);
        repeat (10) @(negedge clk);
        start = 1'b1; op = OP_MTHI; x = 32'd5; y = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle(cyc, gd);
        nCompared++; if (gd !== 1'b1) begin nMismatched++; $display("[TB] FAIL busy_start_done got=%0h want=1", gd); end
        nCompared++; if ({hi, lo} !== 64'h00000012_34567800) begin nMismatched++; $display("[TB] FAIL busy_start_result got=%h_%h want=00000012_34567800", hi, lo); end
    endtask

    task automatic test_cancel();
        int   cyc;
        int   doneSeen;
        logic gd;
        issue(OP_DIVU, 32'd50, 32'd5);
        repeat (15) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL cancel_busy got=%0h want=0", busy); end
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) doneSeen++;
            @(negedge clk);
        end
        nCompared++; if (doneSeen !== 0) begin nMismatched++; $display("[TB] FAIL cancel_no_done got=%0d want=0", doneSeen); end
        nCompared++; if ({hi, lo} !== 64'h00000012_34567800) begin nMismatched++; $display("[TB] FAIL cancel_hilo got=%h_%h want=00000012_34567800", hi, lo); end
        issue(OP_MTLO, 32'd9, 32'd0);
        nCompared++; if ({busy, done, lo} !== {2'b00, 32'd9}) begin nMismatched++; $display("[TB] FAIL mtlo got=%0h%0h_%h want=00_00000009", busy, done, lo); end
        // cancel held in IDLE alongside start: the start still wins
        cancel = 1'b1;
        issue(OP_DIVU, 32'd50, 32'd5);
        cancel = 1'b0;
        nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL cancel_start_busy got=%0h want=1", busy); end
        wait_idle(cyc, gd);
        nCompared++; if ({gd, hi, lo} !== {1'b1, 32'd0, 32'd10}) begin nMismatched++; $display("[TB] FAIL cancel_start_result got=%0h_%h_%h want=1_00000000_0000000a", gd, hi, lo); end
        // cancel landing on the final iteration edge suppresses the write
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (31) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        nCompared++; if ({busy, done, hi, lo} !== {2'b00, 32'd0, 32'd10}) begin nMismatched++; $display("[TB] FAIL cancel_last got=%0h%0h_%h_%h want=00_00000000_0000000a", busy, done, hi, lo); end
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++; if ({busy, done, hi, lo} !== 66'h0) begin nMismatched++; $display("[TB] FAIL reset_mid got=%0h%0h_%h_%h want=00_00000000_00000000", busy, done, hi, lo); end
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        nCompared++; if (doneSeen !== 0) begin nMismatched++; $display("[TB] FAIL reset_mid_after got=%0d want=0", doneSeen); end
    endtask

    // Scenario sequence
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_multu();
        test_signed();
        test_div_edge();
        test_move();
        test_start_while_busy();
        test_cancel();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
